// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types for the data-cache port arbiter.
// Widths default to Sv32: 34-bit physical address, 32-bit data/PTE.
package dcache_port_arbiter_pkg;

    localparam int DC_PALEN = 34;
    localparam int DC_XLEN  = 32;

    localparam logic [3:0] PTE_SEL_BYTE = 4'hF;

    typedef enum logic [2:0] {
        IDLE,
        MMU_BUSY,
        LSU_BUSY,
        DRAIN,
        RESP
    } type_dc_arb_states_e;

    typedef struct packed {
        logic                req;
        logic                w_en;
        logic [3:0]          sel_byte;
        logic [DC_PALEN-1:0] paddr;
        logic [DC_XLEN-1:0]  wdata;
    } type_arb2dcache_s;

    typedef struct packed {
        logic               ack;
        logic [DC_XLEN-1:0] rdata;
    } type_dcache2arb_s;

    // Two-way round-robin: on a tie the side not served last wins.
    function automatic logic grant_mmu(
        input logic mmu_ok,
        input logic lsu_req,
        input logic last_mmu
    );
        return mmu_ok && (!lsu_req || !last_mmu);
    endfunction

endpackage

// File: rtl/dcache_port_arbiter.sv
// Shares the single D-cache port between the page-table walker and the LSU.
// Round-robin grant, registered cache request, response routed to its owner.
module dcache_port_arbiter
    import dcache_port_arbiter_pkg::*;
#(
    parameter int PALEN = 34,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             mmu_req_i,
    input  logic [PALEN-1:0] mmu_paddr_i,
    input  logic             mmu_kill_i,
    output logic             mmu_ack_o,
    output logic [XLEN-1:0]  mmu_rdata_o,

    input  logic             lsu_req_i,
    input  logic             lsu_w_en_i,
    input  logic [3:0]       lsu_sel_byte_i,
    input  logic [PALEN-1:0] lsu_paddr_i,
    input  logic [XLEN-1:0]  lsu_wdata_i,
    output logic             lsu_ack_o,
    output logic [XLEN-1:0]  lsu_rdata_o,

    output logic             dc_req_o,
    output logic             dc_w_en_o,
    output logic [3:0]       dc_sel_byte_o,
    output logic [PALEN-1:0] dc_paddr_o,
    output logic [XLEN-1:0]  dc_wdata_o,
    input  logic             dc_ack_i,
    input  logic [XLEN-1:0]  dc_rdata_i
);

    type_dc_arb_states_e state, state_n;
    logic                last_mmu, last_mmu_n;

    logic             req_n, w_en_n;
    logic [3:0]       sel_n;
    logic [PALEN-1:0] paddr_n;
    logic [XLEN-1:0]  wdata_n;
    logic             mmu_ack_n, lsu_ack_n;
    logic [XLEN-1:0]  mmu_rdata_n, lsu_rdata_n;
    logic             mmu_ok;

    assign mmu_ok = mmu_req_i && !mmu_kill_i;

    always_comb begin
        state_n     = state;
        last_mmu_n  = last_mmu;
        req_n       = dc_req_o;
        w_en_n      = dc_w_en_o;
        sel_n       = dc_sel_byte_o;
        paddr_n     = dc_paddr_o;
        wdata_n     = dc_wdata_o;
        mmu_ack_n   = 1'b0;
        lsu_ack_n   = 1'b0;
        mmu_rdata_n = mmu_rdata_o;
        lsu_rdata_n = lsu_rdata_o;

        unique case (state)
            IDLE: begin
                if (grant_mmu(mmu_ok, lsu_req_i, last_mmu)) begin
                    state_n    = MMU_BUSY;
                    last_mmu_n = 1'b1;
                    req_n      = 1'b1;
                    w_en_n     = 1'b0;
                    sel_n      = PTE_SEL_BYTE;
                    paddr_n    = mmu_paddr_i;
                    wdata_n    = '0;
                end else if (lsu_req_i) begin
                    state_n    = LSU_BUSY;
                    last_mmu_n = 1'b0;
                    req_n      = 1'b1;
                    w_en_n     = lsu_w_en_i;
                    sel_n      = lsu_sel_byte_i;
                    paddr_n    = lsu_paddr_i;
                    wdata_n    = lsu_wdata_i;
                end
            end
            MMU_BUSY: begin
                if (dc_ack_i) begin
                    req_n = 1'b0;
                    if (mmu_kill_i) begin
                        state_n = IDLE;
                    end else begin
                        state_n     = RESP;
                        mmu_ack_n   = 1'b1;
                        mmu_rdata_n = dc_rdata_i;
                    end
                end else if (mmu_kill_i) begin
                    state_n = DRAIN;
                end
            end
            // The cache cannot abandon an issued access; wait it out.
            DRAIN: begin
                if (dc_ack_i) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            LSU_BUSY: begin
                if (dc_ack_i) begin
                    req_n       = 1'b0;
                    state_n     = RESP;
                    lsu_ack_n   = 1'b1;
                    lsu_rdata_n = dc_rdata_i;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_mmu      <= 1'b0;
            dc_req_o      <= 1'b0;
            dc_w_en_o     <= 1'b0;
            dc_sel_byte_o <= '0;
            dc_paddr_o    <= '0;
            dc_wdata_o    <= '0;
            mmu_ack_o     <= 1'b0;
            lsu_ack_o     <= 1'b0;
            mmu_rdata_o   <= '0;
            lsu_rdata_o   <= '0;
        end else begin
            state         <= state_n;
            last_mmu      <= last_mmu_n;
            dc_req_o      <= req_n;
            dc_w_en_o     <= w_en_n;
            dc_sel_byte_o <= sel_n;
            dc_paddr_o    <= paddr_n;
            dc_wdata_o    <= wdata_n;
            mmu_ack_o     <= mmu_ack_n;
            lsu_ack_o     <= lsu_ack_n;
            mmu_rdata_o   <= mmu_rdata_n;
            lsu_rdata_o   <= lsu_rdata_n;
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed cycle tables plus a variable-latency load sequence
// for the D-cache port arbiter.
module tb_dcache_port_arbiter;
    import dcache_port_arbiter_pkg::*;

    localparam int PALEN = 34;
    localparam int XLEN  = 32;

    localparam logic [PALEN-1:0] MMU_PA  = 34'h0_8000_1000;
    localparam logic [PALEN-1:0] LSU_PA  = 34'h0_8000_0004;
    localparam logic [XLEN-1:0]  LSU_WD  = 32'hDEAD_BEEF;
    localparam logic [3:0]       LSU_SEL = 4'b0011;

    logic             clk = 1'b0;
    logic             rst;
    logic             mmu_req_i, mmu_kill_i, mmu_ack_o;
    logic [PALEN-1:0] mmu_paddr_i;
    logic [XLEN-1:0]  mmu_rdata_o;
    logic             lsu_req_i, lsu_w_en_i, lsu_ack_o;
    logic [3:0]       lsu_sel_byte_i;
    logic [PALEN-1:0] lsu_paddr_i;
    logic [XLEN-1:0]  lsu_wdata_i, lsu_rdata_o;
    logic             dc_req_o, dc_w_en_o, dc_ack_i;
    logic [3:0]       dc_sel_byte_o;
    logic [PALEN-1:0] dc_paddr_o;
    logic [XLEN-1:0]  dc_wdata_o, dc_rdata_i;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dcache_port_arbiter #(.PALEN(PALEN), .XLEN(XLEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .mmu_req_i     (mmu_req_i),
        .mmu_paddr_i   (mmu_paddr_i),
        .mmu_kill_i    (mmu_kill_i),
        .mmu_ack_o     (mmu_ack_o),
        .mmu_rdata_o   (mmu_rdata_o),
        .lsu_req_i     (lsu_req_i),
        .lsu_w_en_i    (lsu_w_en_i),
        .lsu_sel_byte_i(lsu_sel_byte_i),
        .lsu_paddr_i   (lsu_paddr_i),
        .lsu_wdata_i   (lsu_wdata_i),
        .lsu_ack_o     (lsu_ack_o),
        .lsu_rdata_o   (lsu_rdata_o),
        .dc_req_o      (dc_req_o),
        .dc_w_en_o     (dc_w_en_o),
        .dc_sel_byte_o (dc_sel_byte_o),
        .dc_paddr_o    (dc_paddr_o),
        .dc_wdata_o    (dc_wdata_o),
        .dc_ack_i      (dc_ack_i),
        .dc_rdata_i    (dc_rdata_i)
    );

    // own: 0 = no cache request, 1 = MMU payload, 2 = LSU payload
    typedef struct {
        bit          rst;
        bit          mreq;
        bit          mkill;
        bit          lreq;
        bit          dack;
        logic [31:0] drd;
        bit [1:0]    own;
        bit          mack;
        bit          lack;
        bit          idle;
        logic [31:0] erd;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit r, input bit mr, input bit mk,
                       input bit lr, input bit da, input logic [31:0] rd,
                       input bit [1:0] own, input bit ma, input bit la,
                       input bit id, input logic [31:0] erd);
        vq.push_back('{r, mr, mk, lr, da, rd, own, ma, la, id, erd});
    endtask

    task automatic chk(input string nm, input int row,
                       input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h",
                     nm, row, act, exp);
        end
    endtask

    task automatic chk_outputs(input int row, input vec_t v);
        chk("dc_req", row, 64'(dc_req_o), 64'(v.own != 0));
        chk("mmu_ack", row, 64'(mmu_ack_o), 64'(v.mack));
        chk("lsu_ack", row, 64'(lsu_ack_o), 64'(v.lack));
        chk("idle", row, 64'(dut.state == IDLE), 64'(v.idle));
        if (v.own == 2'd1) begin
            chk("mmu_paddr", row, 64'(dc_paddr_o), 64'(MMU_PA));
            chk("mmu_w_en", row, 64'(dc_w_en_o), 64'd0);
            chk("mmu_sel", row, 64'(dc_sel_byte_o), 64'hF);
        end
        if (v.own == 2'd2) begin
            chk("lsu_paddr", row, 64'(dc_paddr_o), 64'(LSU_PA));
            chk("lsu_w_en", row, 64'(dc_w_en_o), 64'd1);
            chk("lsu_sel", row, 64'(dc_sel_byte_o), 64'(LSU_SEL));
            chk("lsu_wdata", row, 64'(dc_wdata_o), 64'(LSU_WD));
        end
        if (v.mack) chk("mmu_rdata", row, 64'(mmu_rdata_o), 64'(v.erd));
        if (v.lack) chk("lsu_rdata", row, 64'(lsu_rdata_o), 64'(v.erd));
    endtask

    initial begin
        bit hit;

        rst = 1'b1;
        mmu_req_i = 0; mmu_kill_i = 0; mmu_paddr_i = MMU_PA;
        lsu_req_i = 0; lsu_w_en_i = 1; lsu_sel_byte_i = LSU_SEL;
        lsu_paddr_i = LSU_PA; lsu_wdata_i = LSU_WD;
        dc_ack_i = 0; dc_rdata_i = '0;

        //  rst mr mk lr da drd           own ma la id erd
        // MMU only: cache ack in cycle 3, MMU ack in 4, IDLE in 5
        add(0, 1, 0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,         1, 0, 0, 0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,         1, 0, 0, 0, 32'h0);
        add(0, 1, 0, 0, 1, 32'h2000_00CF, 1, 0, 0, 0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,         0, 1, 0, 0, 32'h2000_00CF);
        add(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h0);
        // reset, then ties alternate starting with the MMU
        add(1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h0);
        add(0, 1, 0, 1, 0, 32'h0,         0, 0, 0, 1, 32'h0);
        add(0, 1, 0, 1, 1, 32'h1111_1111, 1, 0, 0, 0, 32'h0);
        add(0, 1, 0, 1, 0, 32'h0,         0, 1, 0, 0, 32'h1111_1111);
        add(0, 0, 0, 1, 0, 32'h0,         0, 0, 0, 1, 32'h0);
        add(0, 0, 0, 1, 1, 32'h2222_2222, 2, 0, 0, 0, 32'h0);
        add(0, 1, 0, 1, 0, 32'h0,         0, 0, 1, 0, 32'h2222_2222);
        add(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h0);
        add(0, 1, 0, 1, 0, 32'h0,         0, 0, 0, 1, 32'h0);
        add(0, 1, 0, 1, 1, 32'h3333_3333, 1, 0, 0, 0, 32'h0);
        add(0, 1, 0, 1, 0, 32'h0,         0, 1, 0, 0, 32'h3333_3333);
        add(0, 0, 0, 1, 0, 32'h0,         0, 0, 0, 1, 32'h0);
        add(0, 0, 0, 1, 1, 32'h4444_4444, 2, 0, 0, 0, 32'h0);
        add(0, 0, 0, 1, 0, 32'h0,         0, 0, 1, 0, 32'h4444_4444);
        add(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h0);
        // kill while outstanding, drain, pending LSU granted after
        add(0, 1, 0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h0);
        add(0, 1, 0, 1, 0, 32'h0,         1, 0, 0, 0, 32'h0);
        add(0, 1, 1, 1, 0, 32'h0,         1, 0, 0, 0, 32'h0);
        add(0, 0, 0, 1, 0, 32'h0,         1, 0, 0, 0, 32'h0);
        add(0, 0, 0, 1, 0, 32'h0,         1, 0, 0, 0, 32'h0);
        add(0, 0, 0, 1, 1, 32'hBAD0_BAD0, 1, 0, 0, 0, 32'h0);
        add(0, 0, 0, 1, 0, 32'h0,         0, 0, 0, 1, 32'h0);
        add(0, 0, 0, 1, 0, 32'h0,         2, 0, 0, 0, 32'h0);
        // reset during LSU_BUSY
        add(1, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h0);
        // kill with request in IDLE: no grant
        add(0, 1, 1, 0, 0, 32'h0,         0, 0, 0, 1, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h0);
        // kill with cache ack: no MMU ack, IDLE next
        add(0, 1, 0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0,         1, 0, 0, 0, 32'h0);
        add(0, 1, 1, 0, 1, 32'h5555_5555, 1, 0, 0, 0, 32'h0);
        add(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h0);
        // normal LSU store after the reset
        add(0, 0, 0, 1, 0, 32'h0,         0, 0, 0, 1, 32'h0);
        add(0, 0, 0, 1, 1, 32'hCAFE_F00D, 2, 0, 0, 0, 32'h0);
        add(0, 0, 0, 1, 0, 32'h0,         0, 0, 1, 0, 32'hCAFE_F00D);
        add(0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 32'h0);

        #1;
        chk("rst_dc_req", -1, 64'(dc_req_o), 64'd0);
        chk("rst_dc_w_en", -1, 64'(dc_w_en_o), 64'd0);
        chk("rst_dc_sel", -1, 64'(dc_sel_byte_o), 64'd0);
        chk("rst_dc_paddr", -1, 64'(dc_paddr_o), 64'd0);
        chk("rst_dc_wdata", -1, 64'(dc_wdata_o), 64'd0);
        chk("rst_acks", -1, 64'({mmu_ack_o, lsu_ack_o}), 64'd0);
        chk("rst_rdata", -1, {mmu_rdata_o, lsu_rdata_o}, 64'd0);
        chk("rst_idle", -1, 64'(dut.state == IDLE), 64'd1);
        repeat (2) @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            rst        = vq[i].rst;
            mmu_req_i  = vq[i].mreq;
            mmu_kill_i = vq[i].mkill;
            lsu_req_i  = vq[i].lreq;
            dc_ack_i   = vq[i].dack;
            dc_rdata_i = vq[i].drd;
            #3;
            chk_outputs(i, vq[i]);
        end

        // load with a slow cache: request held until it is acked
        @(posedge clk);
        #1;
        lsu_req_i      = 1'b1;
        lsu_w_en_i     = 1'b0;
        lsu_sel_byte_i = 4'b1000;
        lsu_paddr_i    = 34'h2_0000_0010;
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(posedge clk);
            #4;
            hit = dc_req_o;
        end
        chk("load_granted", 100, 64'(hit), 64'd1);
        chk("load_paddr", 100, 64'(dc_paddr_o), 64'h2_0000_0010);
        chk("load_w_en", 100, 64'(dc_w_en_o), 64'd0);
        chk("load_sel", 100, 64'(dc_sel_byte_o), 64'h8);
        lsu_paddr_i = 34'h3_FFFF_FFFC;
        lsu_w_en_i  = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #4;
            chk("load_hold", 101, 64'(dc_req_o), 64'd1);
            chk("load_no_ack", 101, 64'(lsu_ack_o), 64'd0);
            chk("load_paddr_kept", 101, 64'(dc_paddr_o), 64'h2_0000_0010);
        end
        @(posedge clk);
        #1;
        dc_ack_i   = 1'b1;
        dc_rdata_i = 32'h5A5A_1234;
        @(posedge clk);
        #1;
        dc_ack_i = 1'b0;
        #3;
        chk("load_ack", 102, 64'(lsu_ack_o), 64'd1);
        chk("load_rdata", 102, 64'(lsu_rdata_o), 64'h5A5A_1234);
        chk("load_mmu_quiet", 102, 64'(mmu_ack_o), 64'd0);
        chk("load_req_low", 102, 64'(dc_req_o), 64'd0);
        @(posedge clk);
        #1;
        lsu_req_i = 1'b0;
        #3;
        chk("load_ack_once", 103, 64'(lsu_ack_o), 64'd0);
        chk("load_idle", 103, 64'(dut.state == IDLE), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
